// File: rtl/time_report_sequencer.sv
// Serialises a snapshot of the watch time as "HH:MM:SS.CC\r\n" into a UART TX over a
// start/busy handshake; manual and once-per-second requests share one pending slot.
module time_report_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       report_req,
  input  logic       auto_en,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int unsigned AckLimit = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 1 : 1;
  localparam int unsigned CntW     = $clog2(AckLimit + 1);
  localparam logic [3:0]  LastIdx  = 4'd12;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitAck,
    StWaitDone,
    StFinish
  } state_e;

  state_e          state_q;
  logic [3:0]      idx_q;
  logic [CntW-1:0] ack_cnt_q;
  logic [4:0]      hour_q;
  logic [5:0]      min_q;
  logic [5:0]      sec_snap_q;
  logic [6:0]      msec_q;
  logic [5:0]      sec_hist_q;
  logic            pending_q;
  logic            overrun_q;
  logic [7:0]      tx_data_q;

  logic            auto_tick;
  logic            req;
  logic            ack_expired;
  logic [7:0]      frame_byte;

  function automatic logic [7:0] ascii_tens(input logic [6:0] v);
    logic [6:0] t;
    t = (v / 7'd10) % 7'd10;
    return 8'h30 + {1'b0, t};
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [6:0] v);
    logic [6:0] t;
    t = v % 7'd10;
    return 8'h30 + {1'b0, t};
  endfunction

  assign auto_tick   = auto_en && (sec != sec_hist_q);
  assign req         = report_req || auto_tick;
  assign ack_expired = (ack_cnt_q >= CntW'(AckLimit));

  // Digits are converted from the frozen snapshot at send time, so the frame in flight
  // never sees live counter changes.
  always_comb begin
    frame_byte = 8'h0A;
    case (idx_q)
      4'd0:    frame_byte = ascii_tens({2'b00, hour_q});
      4'd1:    frame_byte = ascii_ones({2'b00, hour_q});
      4'd2:    frame_byte = 8'h3A;
      4'd3:    frame_byte = ascii_tens({1'b0, min_q});
      4'd4:    frame_byte = ascii_ones({1'b0, min_q});
      4'd5:    frame_byte = 8'h3A;
      4'd6:    frame_byte = ascii_tens({1'b0, sec_snap_q});
      4'd7:    frame_byte = ascii_ones({1'b0, sec_snap_q});
      4'd8:    frame_byte = 8'h2E;
      4'd9:    frame_byte = ascii_tens(msec_q);
      4'd10:   frame_byte = ascii_ones(msec_q);
      4'd11:   frame_byte = 8'h0D;
      default: frame_byte = 8'h0A;
    endcase
  end

  // Start is issued in the SEND cycle itself so the first byte leaves three cycles
  // after the request; tx_data is held in a register between starts.
  assign tx_start = (state_q == StSend) && !tx_busy && !rst;
  assign tx_data  = tx_start ? frame_byte : tx_data_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFinish);
  assign overrun  = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      ack_cnt_q  <= '0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_snap_q <= 6'd0;
      msec_q     <= 7'd0;
      sec_hist_q <= 6'd0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      sec_hist_q <= sec;
      overrun_q  <= req && pending_q && (state_q != StLoad);

      // LOAD consumes the pending slot; a request in that same cycle queues the next one.
      if (state_q == StLoad) begin
        pending_q <= req;
      end else if (req) begin
        pending_q <= 1'b1;
      end

      if (tx_start) begin
        tx_data_q <= frame_byte;
      end

      unique case (state_q)
        StIdle: begin
          if (pending_q) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          hour_q     <= hour;
          min_q      <= min;
          sec_snap_q <= sec;
          msec_q     <= msec;
          idx_q      <= 4'd0;
          state_q    <= StSend;
        end
        StSend: begin
          if (!tx_busy) begin
            ack_cnt_q <= CntW'(1);
            state_q   <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end else if (ack_expired) begin
            // Transmitter never acknowledged; treat the byte as sent.
            if (idx_q == LastIdx) begin
              state_q <= StFinish;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= StSend;
            end
          end else begin
            ack_cnt_q <= ack_cnt_q + CntW'(1);
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            if (idx_q == LastIdx) begin
              state_q <= StFinish;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= StSend;
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_report_sequencer.sv
// Randomised bench for time_report_sequencer: a behavioural TX model, a byte monitor and
// expected frames formatted from the time values with $sformatf.
module tb_time_report_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       report_req;
  logic       auto_en;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic       overrun;

  time_report_sequencer #(.ACK_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .report_req(report_req),
    .auto_en   (auto_en),
    .msec      (msec),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TX model: busy rises the second cycle after start and stays high tx_b cycles.
  logic tx_ideal = 1'b1;
  int   tx_b     = 2;
  logic st_d1    = 1'b0;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    st_d1 <= tx_start;
    if (st_d1 && tx_ideal) busy_cnt <= tx_b;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor, sampled on the inactive edge.
  logic [7:0] byte_q[$];
  int         start_cyc_q[$];
  int         done_cyc_q[$];
  int         done_cnt = 0;
  int         ovr_cnt  = 0;
  always @(negedge clk) begin
    if (tx_start) begin
      byte_q.push_back(tx_data);
      start_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc_q.push_back(cyc);
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         bb, db, ob;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    bb = byte_q.size();
    db = done_cnt;
    ob = ovr_cnt;
    exp_q.delete();
  endtask

  task automatic push_frame(input int h, input int m, input int s, input int c);
    string str;
    str = $sformatf("%02d:%02d:%02d.%02d", h % 100, m % 100, s % 100, c % 100);
    for (int i = 0; i < 11; i++) exp_q.push_back(str[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_req(output int n);
    n = cyc;
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k = 0;
    while ((done_cnt - db) < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_cnt"}, done_cnt - db, n);
  endtask

  task automatic compare_stream(input string tag, input int interval);
    check({tag, "_nbytes"}, byte_q.size() - bb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bb + i < byte_q.size())
        check($sformatf("%s_b%0d", tag, i), byte_q[bb + i], exp_q[i]);
    end
    if (interval > 0) begin
      for (int i = 1; i < exp_q.size(); i++) begin
        if ((i % 13) != 0 && bb + i < start_cyc_q.size())
          check($sformatf("%s_gap%0d", tag, i),
                start_cyc_q[bb + i] - start_cyc_q[bb + i - 1], interval);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int h, m, s, c;
    rst = 1'b1; report_req = 1'b0; auto_en = 1'b0;
    hour = '0; min = '0; sec = '0; msec = '0;
    repeat (3) tick();
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick();

    // Directed frame with first-byte latency.
    hour = 5'd9; min = 6'd5; sec = 6'd7; msec = 7'd42;
    mark();
    push_frame(9, 5, 7, 42);
    pulse_req(n0);
    tick();
    check("dir_busy_load", busy, 1);
    wait_done("dir", 1, 400);
    if (start_cyc_q.size() > bb) check("dir_latency", start_cyc_q[bb] - n0, 3);
    check("dir_busy_after", busy, 0);
    check("dir_data_hold", tx_data, 8'h0A);
    repeat (20) tick();
    compare_stream("dir", 5);
    check("dir_ovr", ovr_cnt - ob, 0);

    // Random times, random TX busy length, inputs disturbed mid-frame.
    for (int it = 0; it < 5; it++) begin
      h = $urandom_range(0, 31); m = $urandom_range(0, 63);
      s = $urandom_range(0, 63); c = $urandom_range(0, 127);
      tx_b = $urandom_range(1, 5);
      hour = h[4:0]; min = m[5:0]; sec = s[5:0]; msec = c[6:0];
      tick();
      mark();
      push_frame(h, m, s, c);
      pulse_req(n0);
      repeat (5) tick();
      hour = 5'($urandom); min = 6'($urandom); sec = 6'($urandom); msec = 7'($urandom);
      wait_done($sformatf("rnd%0d", it), 1, 600);
      if (start_cyc_q.size() > bb)
        check($sformatf("rnd%0d_latency", it), start_cyc_q[bb] - n0, 3);
      repeat (5) tick();
      compare_stream($sformatf("rnd%0d", it), tx_b + 3);
    end
    tx_b = 2;

    // Auto trigger on 58 -> 59, then no trigger with auto_en low.
    h = 13; m = 47; c = 3;
    hour = 5'd13; min = 6'd47; msec = 7'd3; sec = 6'd58;
    repeat (3) tick();
    auto_en = 1'b1;
    repeat (2) tick();
    mark();
    push_frame(h, m, 59, c);
    sec = 6'd59;
    tick();
    wait_done("auto", 1, 400);
    repeat (20) tick();
    compare_stream("auto", 5);
    auto_en = 1'b0;
    mark();
    sec = 6'd58;
    repeat (30) tick();
    check("noauto_nbytes", byte_q.size() - bb, 0);
    check("noauto_done", done_cnt - db, 0);

    // Manual request coinciding with an auto tick.
    sec = 6'd10;
    tick();
    auto_en = 1'b1;
    repeat (2) tick();
    mark();
    push_frame(13, 47, 11, 3);
    sec = 6'd11;
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    wait_done("both", 1, 400);
    repeat (30) tick();
    compare_stream("both", 5);
    check("both_ovr", ovr_cnt - ob, 0);
    auto_en = 1'b0;
    tick();

    // Three requests: one starts a frame, one queues, one overruns.
    mark();
    push_frame(13, 47, 11, 3);
    push_frame(13, 47, 11, 3);
    pulse_req(n0);
    repeat (20) tick();
    pulse_req(n0);
    repeat (10) tick();
    pulse_req(n0);
    wait_done("ovr", 2, 800);
    repeat (30) tick();
    compare_stream("ovr", 5);
    check("ovr_cnt", ovr_cnt - ob, 1);
    if (start_cyc_q.size() > bb + 13 && done_cyc_q.size() > db)
      check("ovr_requeue_gap", start_cyc_q[bb + 13] - done_cyc_q[db], 3);

    // Transmitter that never acknowledges.
    tx_ideal = 1'b0;
    hour = 5'd23; min = 6'd59; sec = 6'd59; msec = 7'd99;
    tick();
    mark();
    push_frame(23, 59, 59, 99);
    pulse_req(n0);
    wait_done("tmo", 1, 400);
    repeat (5) tick();
    compare_stream("tmo", 8);
    tx_ideal = 1'b1;

    // Reset in the middle of a frame, then a fresh frame.
    hour = 5'd1; min = 6'd2; sec = 6'd3; msec = 7'd4;
    tick();
    mark();
    pulse_req(n0);
    begin
      int k = 0;
      while (byte_q.size() - bb < 6 && k < 200) begin
        tick();
        k++;
      end
    end
    check("rstmid_reached_idx5", byte_q.size() - bb, 6);
    rst = 1'b1;
    tick();
    check("rstmid_tx_start", tx_start, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    repeat (40) tick();
    check("rstmid_no_done", done_cnt - db, 0);
    check("rstmid_no_more_bytes", byte_q.size() - bb, 6);
    mark();
    push_frame(1, 2, 3, 4);
    pulse_req(n0);
    wait_done("fresh", 1, 400);
    repeat (5) tick();
    compare_stream("fresh", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
